// File: rtl/press_event_decoder_if.sv
// press_event_decoder_if: button pulse inputs, event handshake and overflow flag.
interface press_event_decoder_if;
    logic       pulse_in;
    logic       long_pulse_in;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_code;
    logic       overflow;
    logic       clr_overflow;
    modport master (
        output pulse_in, long_pulse_in, evt_ready, clr_overflow,
        input  evt_valid, evt_code, overflow
    );
    modport slave (
        input  pulse_in, long_pulse_in, evt_ready, clr_overflow,
        output evt_valid, evt_code, overflow
    );
endinterface

// File: rtl/press_event_decoder.sv
// press_event_decoder: classifies debounced short/long button pulses into CLICK/DOUBLE/LONG
// events, presented through a one-entry valid/ready holding register with a sticky drop flag.
module press_event_decoder #(
    parameter int WINDOW = 30_000_000
) (
    input logic                  clk,
    input logic                  rst,
    press_event_decoder_if.slave bus
);
    localparam int CW = $clog2(WINDOW + 1);
    localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WAIT2 = 1'b1;
    localparam logic [1:0] CLICK  = 2'b01;
    localparam logic [1:0] DOUBLE = 2'b10;
    localparam logic [1:0] LONG   = 2'b11;
    logic [0:0]    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          new_evt, load, drop;
    logic [1:0]    new_code;
    // Priority long > pulse > timeout falls out of the code selection order.
    always_comb begin
        new_evt  = bus.long_pulse_in || (state == WAIT2 && (bus.pulse_in || cnt == LAST));
        new_code = bus.long_pulse_in ? LONG : bus.pulse_in ? DOUBLE : CLICK;
        state_nx = ((state == IDLE && bus.pulse_in && !bus.long_pulse_in) ||
                    (state == WAIT2 && !new_evt)) ? WAIT2 : IDLE;
        cnt_nx   = (state == WAIT2 && state_nx == WAIT2) ? cnt + CW'(1) : '0;
        load     = new_evt && (!bus.evt_valid || bus.evt_ready);
        drop     = new_evt && bus.evt_valid && !bus.evt_ready;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.evt_valid <= 1'b0;
            bus.evt_code  <= 2'b00;
            bus.overflow  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (load) begin
                bus.evt_valid <= 1'b1;
                bus.evt_code  <= new_code;
            end else if (bus.evt_ready) begin
                bus.evt_valid <= 1'b0;
            end
            bus.overflow <= drop || (bus.overflow && !bus.clr_overflow);
        end
    end
endmodule

// File: tb/tb_press_event_decoder.sv
// tb_press_event_decoder: directed scenarios plus random traffic checked each cycle against a
// timestamp-based reference model of the press classifier and its output register.
module tb_press_event_decoder;
    localparam int W = 16;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    press_event_decoder_if bus();
    press_event_decoder #(.WINDOW(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit pend = 0;
    longint t0 = 0;
    longint now = 0;
    bit mv = 0;
    logic [1:0] mc = 2'b00;
    bit mo = 0;
    bit obs_v [0:511];
    logic [1:0] obs_c [0:511];
    bit obs_o [0:511];
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask
    // Reference: a pending press is a timestamp; CLICK is due exactly W cycles after it.
    task automatic model(input bit r, input bit p, input bit l, input bit rd, input bit cl);
        bit e;
        bit drop;
        logic [1:0] c;
        e = 0; drop = 0; c = 2'b00;
        if (r) begin
            pend = 0; mv = 0; mc = 2'b00; mo = 0;
        end else begin
            if (l) begin e = 1; c = 2'b11; pend = 0; end
            else if (pend && p) begin e = 1; c = 2'b10; pend = 0; end
            else if (pend && now == t0 + W) begin e = 1; c = 2'b01; pend = 0; end
            else if (!pend && p) begin pend = 1; t0 = now; end
            if (e && mv && !rd) drop = 1;
            else if (e) begin mv = 1; mc = c; end
            else if (mv && rd) mv = 0;
            if (drop) mo = 1;
            else if (cl) mo = 0;
        end
        now++;
    endtask
    task automatic step(input bit r, input bit p, input bit l, input bit rd, input bit cl);
        rst = r; bus.pulse_in = p; bus.long_pulse_in = l; bus.evt_ready = rd; bus.clr_overflow = cl;
        @(posedge clk);
        model(r, p, l, rd, cl);
        #1;
        chk("evt_valid", 32'(bus.evt_valid), 32'(mv));
        chk("evt_code", 32'(bus.evt_code), 32'(mc));
        chk("overflow", 32'(bus.overflow), 32'(mo));
        if (cyc + 1 >= 0 && cyc + 1 < 512) begin
            obs_v[cyc+1] = bus.evt_valid;
            obs_c[cyc+1] = bus.evt_code;
            obs_o[cyc+1] = bus.overflow;
        end
        cyc++;
    endtask
    task automatic run_case(input int p1, input int p2, input int l1, input int rc,
                            input int cc, input int rf, input int len);
        cyc = -1;
        step(1, 0, 0, 1, 0);
        for (int c = 0; c < len; c++)
            step(c == rc, c == p1 || c == p2, c == l1, c >= rf, c == cc);
    endtask
    function automatic int nval(input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) n += int'(obs_v[i]);
        return n;
    endfunction
    function automatic int nout(input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) n += int'(obs_v[i]) + int'(obs_c[i]) + int'(obs_o[i]);
        return n;
    endfunction
    initial begin
        bus.pulse_in = 0; bus.long_pulse_in = 0; bus.evt_ready = 1; bus.clr_overflow = 0;
        run_case(10, -1, -1, -1, -1, 0, 60);
        chk("reset_valid", 32'(obs_v[0]), 0);
        chk("click_before", 32'(obs_v[26]), 0);
        chk("click_valid", 32'(obs_v[27]), 1);
        chk("click_code", 32'(obs_c[27]), 1);
        chk("click_once", nval(1, 60), 1);
        run_case(10, 20, -1, -1, -1, 0, 60);
        chk("double_valid", 32'(obs_v[21]), 1);
        chk("double_code", 32'(obs_c[21]), 2);
        chk("double_once", nval(1, 60), 1);
        run_case(10, 26, -1, -1, -1, 0, 60);
        chk("edge_double_valid", 32'(obs_v[27]), 1);
        chk("edge_double_code", 32'(obs_c[27]), 2);
        chk("edge_double_once", nval(1, 60), 1);
        run_case(10, -1, 15, -1, -1, 0, 60);
        chk("long_valid", 32'(obs_v[16]), 1);
        chk("long_code", 32'(obs_c[16]), 3);
        chk("long_once", nval(1, 60), 1);
        run_case(10, -1, 100, -1, -1, 0, 120);
        chk("held_click", 32'(obs_c[27]), 1);
        chk("held_long_valid", 32'(obs_v[101]), 1);
        chk("held_long_code", 32'(obs_c[101]), 3);
        chk("held_two", nval(1, 120), 2);
        run_case(10, 40, -1, -1, 70, 80, 100);
        chk("hold_valid", 32'(obs_v[27]), 1);
        chk("hold_code", 32'(obs_c[60]), 1);
        chk("hold_stable", nval(27, 80), 54);
        chk("ovf_before", 32'(obs_o[56]), 0);
        chk("ovf_set", 32'(obs_o[57]), 1);
        chk("ovf_sticky", 32'(obs_o[70]), 1);
        chk("ovf_clear", 32'(obs_o[71]), 0);
        chk("accept_fall", 32'(obs_v[81]), 0);
        run_case(10, -1, -1, 15, -1, 0, 60);
        chk("rst_no_event", nval(1, 60), 0);
        chk("rst_outputs_zero", nout(16, 60), 0);
        cyc = -1;
        step(1, 0, 0, 1, 0);
        for (int i = 0; i < 4000; i++)
            step($urandom_range(0, 499) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/press_event_decoder.md
PRESS_EVENT_DECODER -- requirements
Module: press_event_decoder

Interface
REQ-001 Parameter WINDOW, default 30_000_000, is the double-click window in clk cycles (300 ms at 100 MHz); legal range is 2 to 2^27-1.
REQ-002 clk  input  1  is the single clock; all logic is rising-edge.
REQ-003 rst  input  1  is a synchronous, active-high reset.
REQ-004 pulse_in  input  1  is a one-cycle short-press pulse from the button debouncer.
REQ-005 long_pulse_in  input  1  is a one-cycle long-press pulse from the button debouncer.
REQ-006 evt_valid  output  1  means a classified event is held on evt_code.
REQ-007 evt_ready  input  1  is the consumer's accept signal.
REQ-008 evt_code  output  2  is the event code: 2'b01 CLICK, 2'b10 DOUBLE, 2'b11 LONG; 2'b00 never appears while evt_valid=1.
REQ-009 overflow  output  1  is a sticky flag that is set when an event is dropped.
REQ-010 clr_overflow  input  1  is a one-cycle clear for overflow.

Function
REQ-011 The FSM SHALL have exactly two states, IDLE and WAIT2, plus a window counter of width $clog2(WINDOW+1).
REQ-012 IDLE, pulse_in=1, long_pulse_in=0 SHALL move to WAIT2 with the counter loaded to 0; no event is produced.
REQ-013 In WAIT2 with no input pulse, the counter SHALL increment by 1 each cycle.
REQ-014 WAIT2, pulse_in=1 SHALL produce DOUBLE and return to IDLE.
REQ-015 WAIT2 with counter==WINDOW-1, pulse_in=0, long_pulse_in=0 SHALL produce CLICK and return to IDLE.
REQ-016 long_pulse_in=1 in either state SHALL produce LONG, cancel any pending CLICK, and go to IDLE.
REQ-017 Simultaneous-event priority SHALL be: long_pulse_in over pulse_in over timeout.
REQ-018 A pulse arriving on the timeout cycle SHALL yield DOUBLE, not CLICK.
REQ-019 A held press (pulse_in at t, long_pulse_in more than WINDOW cycles later) SHALL yield CLICK, then LONG as two separate events; this is intended.
REQ-020 Event latency: an event SHALL be "produced" in the cycle its deciding condition is sampled, and evt_valid/evt_code SHALL be registered so they appear on the following cycle.
REQ-021 Output SHALL be a one-entry holding register: evt_valid stays 1 and evt_code stays stable until a cycle with evt_valid=1 and evt_ready=1.
REQ-022 On an accept cycle with no new event, evt_valid SHALL go to 0 on the next cycle.
REQ-023 On an accept cycle with a new event, the new event SHALL load with evt_valid staying 1 (back-to-back, no bubble).
REQ-024 A new event produced while evt_valid=1 and evt_ready=0 SHALL be dropped, with the register unchanged, and overflow set to 1 on the next cycle.
REQ-025 The FSM SHALL advance regardless of a dropped event.
REQ-026 overflow SHALL clear on the cycle after clr_overflow=1.
REQ-027 If clr_overflow coincides with a new drop, overflow SHALL remain 1 (set wins).
REQ-028 evt_ready SHALL be ignored while evt_valid=0.
REQ-029 The counter SHALL never wrap; it is only used in WAIT2 and is reloaded on entry.

Reset
REQ-030 rst=1 SHALL force, on the next edge: state=IDLE, counter=0, evt_valid=0, evt_code=2'b00, overflow=0.
REQ-031 rst SHALL take priority over all inputs.
REQ-032 rst asserted mid-WAIT2 SHALL discard the pending CLICK; no event follows reset release without a new pulse.
REQ-033 Inputs present on a cycle with rst=1 SHALL be ignored.

Verification (WINDOW=16, evt_ready=1 unless stated)
REQ-034 The bench SHALL cover: pulse_in at cycle 10, no further input -> CLICK (evt_code=01) with evt_valid=1 at cycle 27 for one cycle.
REQ-035 The bench SHALL cover: pulse_in at 10 and 20 -> DOUBLE (10) at cycle 21; no CLICK follows.
REQ-036 The bench SHALL cover: pulse_in at 10 and 26 (timeout cycle) -> DOUBLE at 27 only.
REQ-037 The bench SHALL cover: pulse_in at 10, long_pulse_in at 15 -> LONG (11) at 16, no CLICK; separately, pulse_in at 10 and long_pulse_in at 100 -> CLICK at 27 and LONG at 101.
REQ-038 The bench SHALL cover: evt_ready=0 from cycle 0, two CLICK-generating press sequences -> first CLICK held stable, second dropped, overflow=1 until clr_overflow; then evt_ready=1 accepts the first and evt_valid falls next cycle.
REQ-039 The bench SHALL cover: pulse_in at 10, rst=1 at 15 for one cycle -> no event through cycle 60, all outputs 0 from cycle 16.
